// File: rtl/sentinel_seq_lock.sv
// Multi-key sequence lock: each key must be strobed inside a cycle window after the
// previous event; consecutive failures escalate to a timed, non-abortable lockout.
module sentinel_seq_lock #(
  parameter int unsigned KEY_W                     = 8,
  parameter int unsigned SEQ_LEN                   = 3,
  parameter logic [SEQ_LEN*KEY_W-1:0] KEY_SEQ      = 24'h5A_C3_B6,
  parameter int unsigned WIN_MIN                   = 3,
  parameter int unsigned WIN_MAX                   = 5,
  parameter int unsigned MAX_FAILS                 = 3,
  parameter int unsigned LOCKOUT_CYCLES            = 250_000_000
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           arm,
  input  logic [KEY_W-1:0]               key_in,
  input  logic                           key_valid,
  output logic                           authorized,
  output logic                           locked_out,
  output logic [$clog2(SEQ_LEN+1)-1:0]   stage,
  output logic [$clog2(MAX_FAILS+1)-1:0] fail_count,
  output logic                           fail_pulse,
  output logic [7:0]                     seg_out
);

  localparam int unsigned STG_W = $clog2(SEQ_LEN+1);
  localparam int unsigned FC_W  = $clog2(MAX_FAILS+1);
  localparam int unsigned TMR_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

  localparam logic [5:0]       WMIN     = 6'(WIN_MIN);
  localparam logic [5:0]       WMAX     = 6'(WIN_MAX);
  localparam logic [STG_W-1:0] STG_LAST = STG_W'(SEQ_LEN-1);
  localparam logic [STG_W-1:0] STG_FULL = STG_W'(SEQ_LEN);
  localparam logic [FC_W-1:0]  FC_MAX   = FC_W'(MAX_FAILS);
  localparam logic [TMR_W-1:0] TMR_INIT = TMR_W'(LOCKOUT_CYCLES-1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_AUTH, S_LOCK} state_t;

  state_t           state_q, state_d;
  logic             arm_q;
  logic [5:0]       cnt_q, cnt_d;
  logic [STG_W-1:0] stage_q, stage_d;
  logic [FC_W-1:0]  fc_q, fc_d, fc_inc;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             fail_q, fail_d;
  logic [KEY_W-1:0] exp_key;
  logic             in_win, failure;

  always_comb begin
    exp_key = '0;
    for (int unsigned k = 0; k < SEQ_LEN; k++) begin
      if (stage_q == STG_W'(k)) exp_key = KEY_SEQ[k*KEY_W +: KEY_W];
    end
  end

  assign in_win = (cnt_q >= WMIN) && (cnt_q <= WMAX);
  assign fc_inc = fc_q + FC_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    fc_d    = fc_q;
    timer_d = timer_q;
    fail_d  = 1'b0;
    failure = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (arm && !arm_q) begin
          state_d = S_WAIT;
          cnt_d   = '0;
          stage_d = '0;
        end
      end
      S_WAIT: begin
        cnt_d = (cnt_q == 6'd63) ? cnt_q : cnt_q + 6'd1;
        // Abort outranks any strobe or timeout in the same cycle.
        if (!arm) begin
          state_d = S_IDLE;
          stage_d = '0;
        end else if (key_valid) begin
          if (key_in == exp_key && in_win) begin
            cnt_d = '0;
            if (stage_q == STG_LAST) begin
              state_d = S_AUTH;
              stage_d = STG_FULL;
              fc_d    = '0;
            end else begin
              stage_d = stage_q + STG_W'(1);
            end
          end else begin
            failure = 1'b1;
          end
        end else if (cnt_q == WMAX) begin
          failure = 1'b1;
        end
        if (failure) begin
          fail_d  = 1'b1;
          fc_d    = fc_inc;
          stage_d = '0;
          if (fc_inc == FC_MAX) begin
            state_d = S_LOCK;
            timer_d = TMR_INIT;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_AUTH: begin
        if (!arm) begin
          state_d = S_IDLE;
          stage_d = '0;
        end
      end
      S_LOCK: begin
        if (timer_q == '0) begin
          state_d = S_IDLE;
          fc_d    = '0;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        stage_d = '0;
        fc_d    = '0;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      arm_q   <= 1'b0;
      cnt_q   <= '0;
      stage_q <= '0;
      fc_q    <= '0;
      timer_q <= '0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      arm_q   <= arm;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      fc_q    <= fc_d;
      timer_q <= timer_d;
      fail_q  <= fail_d;
    end
  end

  assign authorized = (state_q == S_AUTH);
  assign locked_out = (state_q == S_LOCK);
  assign stage      = stage_q;
  assign fail_count = fc_q;
  assign fail_pulse = fail_q;
  assign seg_out    = (state_q == S_AUTH) ? 8'hC1 :
                      (state_q == S_LOCK) ? 8'h86 : 8'hC7;

endmodule

// File: doc/sentinel_seq_lock.md
Name: sentinel_seq_lock

Overview:
Parametrised multi-key sequence lock with a per-key time window and escalating lockout. It is the next-generation Sentinel gate. An arm edge opens a session, and SEQ_LEN keys must each be strobed inside a [WIN_MIN, WIN_MAX] cycle window measured from the previous event. Wrong keys, early or late strobes, and timeouts count as failures. MAX_FAILS consecutive failures force a non-abortable lockout. The block sits between the key-interface pins and the display/status drivers at top level.

Parameters:
KEY_W, 8, width of each key
SEQ_LEN, 3, number of keys in the sequence (>=1)
KEY_SEQ, 24'h5A_C3_B6, packed keys; key k = KEY_SEQ[k*KEY_W +: KEY_W], so key0 = 0xB6
WIN_MIN, 3, earliest valid strobe offset (cycles)
WIN_MAX, 5, latest valid strobe offset (WIN_MIN <= WIN_MAX <= 62)
MAX_FAILS, 3, consecutive failures that trigger lockout (>=1)
LOCKOUT_CYCLES, 250_000_000, lockout duration in cycles (10 s at 25 MHz)

Ports:
clk  in  1  system clock; the only clock
rst_n  in  1  synchronous, active-low reset
arm  in  1  session enable; a rising edge opens a session
key_in  in  KEY_W  presented key
key_valid  in  1  single-cycle strobe qualifying key_in
authorized  out  1  high while in AUTH
locked_out  out  1  high while in LOCKOUT
stage  out  $clog2(SEQ_LEN+1)  number of keys accepted in the current session
fail_count  out  $clog2(MAX_FAILS+1)  consecutive failure count
fail_pulse  out  1  one-cycle pulse, registered, on each failure
seg_out  out  8  active-low 7-seg {dp,g,f,e,d,c,b,a}: 0xC7 in IDLE/WAIT, 0xC1 in AUTH, 0x86 ('E') in LOCKOUT

Behaviour:
- Clock and reset: one clock, clk. rst_n is synchronous and active-low.
- Reset values: state=IDLE, arm_q=0, cnt=0, stage=0, fail_count=0, timer=0, all flags 0, seg_out=0xC7. Reset mid-lockout clears the lockout and fail_count.
- Registered outputs: all outputs are registered or decoded from registered state only. A response appears 1 cycle after the triggering input.
- Edge detection: arm_q <= arm every cycle. Rising edge = arm & ~arm_q.
- IDLE:
  - On a rising edge -> WAIT, cnt=0, stage=0.
  - key_valid is ignored.
  - If arm is already high on entry, a new session needs arm to go low and then high again.
- WAIT: cnt increments each cycle, saturating at 63. The current offset is cnt.
  - arm==0 -> IDLE, no failure counted (abort). This has priority over every other WAIT event in the same cycle.
  - key_valid with key_in==key[stage] and WIN_MIN<=cnt<=WIN_MAX -> accept: stage+1, cnt=0. If this was the last key, go to AUTH and clear fail_count.
  - key_valid with a wrong key, or with cnt<WIN_MIN, or with cnt>WIN_MAX -> failure.
  - No key_valid while cnt==WIN_MAX -> failure (timeout). The failure is registered on that edge.
- Failure handling:
  - fail_pulse=1 for one cycle, fail_count+1.
  - If the new count == MAX_FAILS -> LOCKOUT, timer=LOCKOUT_CYCLES-1.
  - Otherwise -> IDLE, stage=0.
- AUTH:
  - Hold while arm==1. key_valid is ignored.
  - arm==0 -> IDLE, stage=0.
- LOCKOUT:
  - arm and key_valid are ignored; the lockout cannot be aborted.
  - The timer decrements each cycle. locked_out is high for exactly LOCKOUT_CYCLES cycles.
  - Timer==0 -> IDLE, fail_count=0.
- Timer width: $clog2(LOCKOUT_CYCLES).
- Key compare: full KEY_W-bit equality. No partial match.
- Illegal state encodings recover to IDLE with all counters cleared.

Test Plan (LOCKOUT_CYCLES=20, other parameters at default):
- Happy path: reset, raise arm at T0, strobe 0xB6 @offset 3, 0xC3 @offset 4, 0x5A @offset 5 -> authorized=1 one cycle after the 3rd strobe. stage=3, seg_out=0xC1, fail_count=0.
- Window edges: strobe 0xB6 @offset 2 -> fail_pulse, fail_count=1, IDLE. Retry with @offset 6 -> fail_count=2. Retry with @offset 5 -> accepted, stage=1.
- Timeout and wrong key: no strobe after arm -> fail on the cycle after cnt==5. Next session: key0 correct, then 0xFF @offset 4 -> fail, stage=0, fail_count=2.
- Lockout: 3 consecutive failures -> locked_out=1, seg_out=0x86 for exactly 20 cycles. Toggling arm and strobing the correct keys during lockout has no effect. Afterwards: IDLE, fail_count=0, seg_out=0xC7.
- Abort and priority: arm drops in the same cycle as a wrong-key strobe -> IDLE, no fail_pulse, fail_count unchanged. Arm held high after return to IDLE -> no new session until arm toggles.
- Reset: assert rst_n=0 for 1 cycle mid-lockout and mid-AUTH -> all outputs return to reset values on the next edge.
